// File: rtl/rr_mux.sv
// N-channel registered multiplexer with valid/ready handshakes on each side.
// The source channel is chosen by a round-robin (MODE 0) or fixed-priority (MODE 1) arbiter.
module rr_mux #(
    parameter  int unsigned N     = 4,
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned MODE  = 0,
    localparam int unsigned SELW  = (N > 2) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SELW-1:0]    out_sel
);

    logic [SELW-1:0]  r_ptr;
    logic [SELW-1:0]  r_out_sel;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;

    logic             w_load;
    logic             w_found;
    int unsigned      w_gnt;
    int unsigned      w_idx;
    logic [SELW-1:0]  w_ptr_nxt;

    assign w_load = !r_out_valid || out_ready;

    // Search from the pointer (round-robin) or from channel 0 (fixed priority).
    always_comb begin
        w_found = 1'b0;
        w_gnt   = 0;
        w_idx   = 0;
        for (int unsigned k = 0; k < N; k++) begin
            if (MODE == 0) begin
                w_idx = (32'(r_ptr) + k) % N;
            end else begin
                w_idx = k;
            end
            if (!w_found && in_valid[w_idx]) begin
                w_found = 1'b1;
                w_gnt   = w_idx;
            end
        end
    end

    assign w_ptr_nxt = (w_gnt == N - 1) ? '0 : SELW'(w_gnt + 1);

    // Held in reset, a channel must not see an accept that will not be honoured.
    assign in_ready = (rst_n && w_load && w_found) ? (N'(1) << w_gnt) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            r_out_sel   <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= w_found;
            if (w_found) begin
                r_out_data <= in_data[w_gnt*WIDTH +: WIDTH];
                r_out_sel  <= SELW'(w_gnt);
                if (MODE == 0) begin
                    r_ptr <= w_ptr_nxt;
                end
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_rr_mux.sv
// Directed self-checking bench for rr_mux: round-robin N=4, round-robin N=3 and fixed-priority N=4.
module tb_rr_mux;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [31:0] a_data;
    logic [3:0]  a_valid;
    logic [3:0]  a_ready;
    logic [7:0]  a_odata;
    logic        a_ovalid;
    logic        a_oready;
    logic [1:0]  a_sel;

    logic [23:0] b_data;
    logic [2:0]  b_valid;
    logic [2:0]  b_ready;
    logic [7:0]  b_odata;
    logic        b_ovalid;
    logic        b_oready;
    logic [1:0]  b_sel;

    logic [31:0] f_data;
    logic [3:0]  f_valid;
    logic [3:0]  f_ready;
    logic [7:0]  f_odata;
    logic        f_ovalid;
    logic        f_oready;
    logic [1:0]  f_sel;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rr_mux #(.N(4), .WIDTH(8), .MODE(0)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
        .out_data(a_odata), .out_valid(a_ovalid), .out_ready(a_oready), .out_sel(a_sel)
    );

    rr_mux #(.N(3), .WIDTH(8), .MODE(0)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
        .out_data(b_odata), .out_valid(b_ovalid), .out_ready(b_oready), .out_sel(b_sel)
    );

    rr_mux #(.N(4), .WIDTH(8), .MODE(1)) dutf (
        .clk(clk), .rst_n(rst_n), .in_data(f_data), .in_valid(f_valid), .in_ready(f_ready),
        .out_data(f_odata), .out_valid(f_ovalid), .out_ready(f_oready), .out_sel(f_sel)
    );

    task automatic do_reset();
        a_valid = '0; b_valid = '0; f_valid = '0;
        a_oready = 1'b0; b_oready = 1'b0; f_oready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        a_data = '0; b_data = '0; f_data = '0;
        do_reset();
        checks++;
        if (a_ovalid !== 1'b0 || a_odata !== 8'h00 || a_sel !== 2'd0) begin
            errs++;
            $display("FAIL reset_initial: valid=%0b data=%0h sel=%0d, expected 0/0/0", a_ovalid, a_odata, a_sel);
        end
        a_data = 32'h44332211;
        a_valid = 4'b1111;
        @(negedge clk);
        checks++;
        if (a_ovalid !== 1'b1 || a_sel !== 2'd0 || a_odata !== 8'h11) begin
            errs++;
            $display("FAIL reset_preload: valid=%0b sel=%0d data=%0h, expected 1/0/11", a_ovalid, a_sel, a_odata);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (a_ovalid !== 1'b0) begin
            errs++; $display("FAIL reset_async_valid: got %0b expected 0", a_ovalid);
        end
        checks++;
        if (a_odata !== 8'h00) begin
            errs++; $display("FAIL reset_async_data: got %0h expected 0", a_odata);
        end
        checks++;
        if (a_sel !== 2'd0) begin
            errs++; $display("FAIL reset_async_sel: got %0d expected 0", a_sel);
        end
        checks++;
        if (a_ready !== 4'b0000) begin
            errs++; $display("FAIL reset_async_ready: got %b expected 0000", a_ready);
        end
        a_valid = 4'b0100;
        a_data = 32'h005A0000;
        a_oready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (a_ovalid !== 1'b1 || a_odata !== 8'h5A || a_sel !== 2'd2) begin
            errs++;
            $display("FAIL reset_first_grant: valid=%0b data=%0h sel=%0d, expected 1/5a/2", a_ovalid, a_odata, a_sel);
        end
    endtask

    task automatic test_rr_fairness();
        logic [1:0] exp_sel;
        do_reset();
        for (int i = 0; i < 4; i++) a_data[i*8 +: 8] = 8'(8'h10 + i);
        a_valid = 4'b1111;
        a_oready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            exp_sel = 2'(i % 4);
            checks++;
            if (a_ovalid !== 1'b1 || a_sel !== exp_sel || a_odata !== 8'(8'h10 + exp_sel)) begin
                errs++;
                $display("FAIL rr_seq[%0d]: valid=%0b sel=%0d data=%0h, expected 1/%0d/%0h",
                         i, a_ovalid, a_sel, a_odata, exp_sel, 8'(8'h10 + exp_sel));
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        a_data = 32'hA3A2A1A0;
        a_valid = 4'b0010;
        a_oready = 1'b1;
        @(negedge clk);
        a_oready = 1'b0;
        a_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (a_ovalid !== 1'b1 || a_odata !== 8'hA1 || a_sel !== 2'd1 || a_ready !== 4'b0000) begin
                errs++;
                $display("FAIL stall[%0d]: valid=%0b data=%0h sel=%0d ready=%b, expected 1/a1/1/0000",
                         i, a_ovalid, a_odata, a_sel, a_ready);
            end
            @(negedge clk);
        end
        a_oready = 1'b1;
        #1;
        checks++;
        if (a_ready !== 4'b0100) begin
            errs++; $display("FAIL release_ready: got %b expected 0100", a_ready);
        end
        @(negedge clk);
        checks++;
        if (a_ovalid !== 1'b1 || a_sel !== 2'd2 || a_odata !== 8'hA2) begin
            errs++;
            $display("FAIL release_grant: valid=%0b sel=%0d data=%0h, expected 1/2/a2", a_ovalid, a_sel, a_odata);
        end
    endtask

    task automatic test_wrap();
        logic [1:0] exp_sel;
        logic [1:0] exp_ptr;
        do_reset();
        b_data = 24'h323130;
        b_valid = 3'b101;
        b_oready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            exp_sel = (i % 2 == 0) ? 2'd0 : 2'd2;
            exp_ptr = (i % 2 == 0) ? 2'd1 : 2'd0;
            checks++;
            if (b_ovalid !== 1'b1 || b_sel !== exp_sel || b_odata !== 8'(8'h30 + exp_sel)) begin
                errs++;
                $display("FAIL wrap_seq[%0d]: valid=%0b sel=%0d data=%0h, expected 1/%0d/%0h",
                         i, b_ovalid, b_sel, b_odata, exp_sel, 8'(8'h30 + exp_sel));
            end
            checks++;
            if (dut3.r_ptr !== exp_ptr) begin
                errs++; $display("FAIL wrap_ptr[%0d]: got %0d expected %0d", i, dut3.r_ptr, exp_ptr);
            end
        end
    endtask

    task automatic test_fixed_priority();
        do_reset();
        f_data = 32'hF3F2F1F0;
        f_valid = 4'b1001;
        f_oready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (f_ready !== 4'b0001) begin
                errs++; $display("FAIL fixed_ready[%0d]: got %b expected 0001", i, f_ready);
            end
            @(negedge clk);
            checks++;
            if (f_ovalid !== 1'b1 || f_sel !== 2'd0 || f_odata !== 8'hF0) begin
                errs++;
                $display("FAIL fixed_grant[%0d]: valid=%0b sel=%0d data=%0h, expected 1/0/f0", i, f_ovalid, f_sel, f_odata);
            end
        end
        f_valid = 4'b1000;
        @(negedge clk);
        checks++;
        if (f_ovalid !== 1'b1 || f_sel !== 2'd3 || f_odata !== 8'hF3) begin
            errs++;
            $display("FAIL fixed_drop0: valid=%0b sel=%0d data=%0h, expected 1/3/f3", f_ovalid, f_sel, f_odata);
        end
        checks++;
        if (dutf.r_ptr !== 2'd0) begin
            errs++; $display("FAIL fixed_ptr: got %0d expected 0", dutf.r_ptr);
        end
    endtask

    task automatic test_idle_gap();
        do_reset();
        a_data = 32'h0000B100;
        a_valid = 4'b0010;
        a_oready = 1'b1;
        @(negedge clk);
        a_valid = 4'b0000;
        checks++;
        if (a_ovalid !== 1'b1 || a_sel !== 2'd1 || a_odata !== 8'hB1) begin
            errs++;
            $display("FAIL idle_word: valid=%0b sel=%0d data=%0h, expected 1/1/b1", a_ovalid, a_sel, a_odata);
        end
        @(negedge clk);
        checks++;
        if (a_ovalid !== 1'b0 || a_odata !== 8'hB1 || a_sel !== 2'd1) begin
            errs++;
            $display("FAIL idle_after: valid=%0b data=%0h sel=%0d, expected 0/b1/1", a_ovalid, a_odata, a_sel);
        end
        checks++;
        if (dut.r_ptr !== 2'd2) begin
            errs++; $display("FAIL idle_ptr: got %0d expected 2", dut.r_ptr);
        end
        @(negedge clk);
        checks++;
        if (a_ovalid !== 1'b0) begin
            errs++; $display("FAIL idle_stays: got %0b expected 0", a_ovalid);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_rr_fairness();
        test_backpressure();
        test_wrap();
        test_fixed_priority();
        test_idle_gap();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/rr_mux.md
# rr_mux

Parametrised N-channel, WIDTH-bit registered multiplexer with valid/ready handshakes on every input and on the output. An internal arbiter chooses the source channel, either round-robin or fixed priority. It generalises the single-bit 2:1 select mux. The block sits wherever several producers share one downstream consumer, such as register-file write ports or bus masters. It provides one cycle of output registering and sustains full throughput.

## Interface
- N, default 4: number of input channels; legal range 2..16.
- WIDTH, default 8: data width per channel; must be at least 1.
- MODE, default 0: 0 selects round-robin, 1 selects fixed priority (lowest index wins).
- SELW is derived, not overridable: max(1, ceil(log2 N)).

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  sole clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset; asserts immediately, deasserts synchronously to clk.
- in_data  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  N  per-channel data-valid.
- in_ready  out  N  per-channel accept; combinational from state, in_valid and out_ready.
- out_data  out  WIDTH  registered data.
- out_valid  out  1  registered; out_data holds a word.
- out_ready  in  1  consumer accept.
- out_sel  out  SELW  registered index of the channel that supplied out_data.

## Operation
- Transfer rule: a transfer occurs on a channel when its valid and ready are both high at a rising clk edge.
- Load enable: load = !out_valid || out_ready.
- Grant when load=1 and some in_valid is high:
  - Exactly one channel g is granted and in_ready[g]=1.
  - All other in_ready bits are 0.
  - At the edge: out_data <= channel g data, out_sel <= g, out_valid <= 1.
- Load with no request: load=1 and in_valid == 0 gives out_valid <= 0. out_data and out_sel hold their previous values.
- Stall: load=0 forces all in_ready to 0, and out_data, out_sel and out_valid hold. The output stays stable while out_valid && !out_ready.
- MODE 0 (round-robin):
  - A pointer ptr (SELW bits) marks the highest-priority channel.
  - Search order is ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
  - After a grant to g, ptr <= (g+1) mod N. Wrap is explicit mod N and holds for non-power-of-two N: from N-1 the pointer returns to 0.
  - No grant leaves ptr unchanged.
- MODE 1 (fixed priority): the lowest-index valid channel wins. ptr is unused and stays 0.
- in_valid is sampled only as a request. Input data is never stored unless that channel is granted.
- No data loss or duplication: each input transfer produces exactly one output transfer, in grant order.

## Timing
- Reset values (while rst_n=0): out_valid=0, out_data=0, out_sel=0, ptr=0, in_ready all 0.
- Latency: an input accepted at edge k is presented with out_valid=1 from edge k until the output transfer.
- Throughput: with out_ready held at 1, one word per cycle is sustained.
- Simultaneous output drain and new grant in one cycle: the register is refilled with no bubble.
- Reset mid-operation: a word held in the register is discarded; out_valid falls asynchronously. The first grant after rst_n rises starts at channel 0.
- Changing in_valid while not granted is legal and has no effect on state.

## Test plan
- Reset: assert rst_n=0 mid-stream with out_valid=1 -> out_valid, out_data, out_sel and in_ready read 0 within the same cycle. After release with only channel 2 valid (data 0x5A), the next edge gives out_data=0x5A and out_sel=2.
- Round-robin fairness: N=4, MODE=0, all channels valid with data 0x10+i, out_ready=1 -> out_sel sequence 0,1,2,3,0,1 on consecutive cycles, with no idle cycles.
- Backpressure: load channel 1 (0xA1), then hold out_ready=0 for 5 cycles with all in_valid=1 -> out_data stays 0xA1, out_sel stays 1, in_ready=0000 throughout. Raising out_ready then gives a grant to channel 2 on the same edge the 0xA1 transfer completes.
- Non-power-of-two wrap: N=3, channels 0 and 2 valid -> grants alternate 0,2,0,2; after granting 2, ptr returns to 0.
- Fixed priority: MODE=1, channels 0 and 3 continuously valid -> channel 0 granted every cycle and in_ready[3] stays 0. Dropping in_valid[0] gives a grant to 3 on the next edge.
- Idle gap: a single word from channel 1, then no requests, out_ready=1 -> out_valid is 1 for exactly one cycle then 0. out_data holds its last value; ptr=2.
